// File: rtl/mem_stage_pkg.sv
// Shared widths, opcode constants and opcode classification helpers for mem_stage.
package mem_stage_pkg;

    localparam int BUS_64   = 64;
    localparam int BUS_32   = 32;
    localparam int BUS_RIDX = 5;

    localparam logic [7:0] INST_ADD = 8'h01;
    localparam logic [7:0] INST_SUB = 8'h02;
    localparam logic [7:0] INST_LB  = 8'h20;
    localparam logic [7:0] INST_LH  = 8'h21;
    localparam logic [7:0] INST_LW  = 8'h22;
    localparam logic [7:0] INST_LD  = 8'h23;
    localparam logic [7:0] INST_LBU = 8'h24;
    localparam logic [7:0] INST_LHU = 8'h25;
    localparam logic [7:0] INST_LWU = 8'h26;
    localparam logic [7:0] INST_SB  = 8'h28;
    localparam logic [7:0] INST_SH  = 8'h29;
    localparam logic [7:0] INST_SW  = 8'h2A;
    localparam logic [7:0] INST_SD  = 8'h2B;

    function automatic logic is_load_op(input logic [7:0] opc);
        case (opc)
            INST_LB, INST_LH, INST_LW, INST_LD,
            INST_LBU, INST_LHU, INST_LWU: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] opc);
        case (opc)
            INST_SB, INST_SH, INST_SW, INST_SD: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Byte-enable pattern for an access starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [7:0] opc);
        case (opc)
            INST_LB, INST_LBU, INST_SB: return 8'h01;
            INST_LH, INST_LHU, INST_SH: return 8'h03;
            INST_LW, INST_LWU, INST_SW: return 8'h0F;
            INST_LD, INST_SD:           return 8'hFF;
            default:                    return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for data-memory accesses: store mask/data shifting and
// load extraction with sign or zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]        opcode,
    input  logic [2:0]        offset,
    input  logic [BUS_64-1:0] store_data,
    input  logic [BUS_64-1:0] rdata,
    output logic [7:0]        wmask,
    output logic [BUS_64-1:0] wdata,
    output logic [BUS_64-1:0] load_data
);

    logic [5:0]        shamt;
    logic [BUS_64-1:0] shifted;

    assign shamt = {offset, 3'b000};

    // Lanes past byte 7 fall off the shift, truncating doubleword-crossing accesses.
    always_comb begin
        wmask   = size_mask(opcode) << offset;
        wdata   = store_data << shamt;
        shifted = rdata >> shamt;
        case (opcode)
            INST_LB:  load_data = {{56{shifted[7]}}, shifted[7:0]};
            INST_LH:  load_data = {{48{shifted[15]}}, shifted[15:0]};
            INST_LW:  load_data = {{32{shifted[31]}}, shifted[31:0]};
            INST_LBU: load_data = {56'd0, shifted[7:0]};
            INST_LHU: load_data = {48'd0, shifted[15:0]};
            INST_LWU: load_data = {32'd0, shifted[31:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one executed instruction in, at most one dmem access,
// one result out. Define MEM_STAGE_MMIO_SKIP_EN to flag low-address accesses as skip-commit.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_mem_executed_req,
    output logic                o_mem_executed_ack,
    input  logic [4:0]          i_mem_inst_type,
    input  logic [7:0]          i_mem_inst_opcode,
    input  logic [BUS_64-1:0]   i_mem_pc,
    input  logic [BUS_32-1:0]   i_mem_inst,
    input  logic [BUS_64-1:0]   i_mem_op1,
    input  logic [BUS_64-1:0]   i_mem_op2,
    input  logic [BUS_64-1:0]   i_mem_op3,
    input  logic [BUS_RIDX-1:0] i_mem_rd,
    input  logic                i_mem_rd_wen,
    input  logic [BUS_64-1:0]   i_mem_rd_wdata,
    input  logic                i_mem_nocmt,
    input  logic                i_mem_skipcmt,
    output logic                o_mem_dmem_req,
    input  logic                i_mem_dmem_ack,
    output logic                o_mem_dmem_wen,
    output logic [BUS_64-1:0]   o_mem_dmem_addr,
    output logic [BUS_64-1:0]   o_mem_dmem_wdata,
    output logic [7:0]          o_mem_dmem_wmask,
    input  logic [BUS_64-1:0]   i_mem_dmem_rdata,
    output logic                o_mem_memoryed_req,
    input  logic                i_mem_memoryed_ack,
    output logic [BUS_64-1:0]   o_mem_pc,
    output logic [BUS_32-1:0]   o_mem_inst,
    output logic [BUS_RIDX-1:0] o_mem_rd,
    output logic                o_mem_rd_wen,
    output logic [BUS_64-1:0]   o_mem_rd_wdata,
    output logic                o_mem_nocmt,
    output logic                o_mem_skipcmt
);

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t              state;
    logic [BUS_64-1:0]   pc_q;
    logic [BUS_32-1:0]   inst_q;
    logic [7:0]          opcode_q;
    logic [BUS_RIDX-1:0] rd_q;
    logic                rd_wen_q;
    logic [BUS_64-1:0]   rd_wdata_q;
    logic                nocmt_q;
    logic                skipcmt_q;
    logic [BUS_64-1:0]   addr_q;
    logic [BUS_64-1:0]   store_data_q;
    logic                load_q;
    logic                store_q;
    logic                dmem_req_q;
    logic                memoryed_req_q;

    logic [7:0]          align_wmask;
    logic [BUS_64-1:0]   align_wdata;
    logic [BUS_64-1:0]   align_load;
    logic                in_load;
    logic                in_store;
    logic                wb_fire;
    logic                skip_eff;
    logic [4:0]          unused_inst_type;

    assign unused_inst_type = i_mem_inst_type;
    assign in_load          = is_load_op(i_mem_inst_opcode);
    assign in_store         = is_store_op(i_mem_inst_opcode);

    mem_align u_align (
        .opcode     (opcode_q),
        .offset     (addr_q[2:0]),
        .store_data (store_data_q),
        .rdata      (i_mem_dmem_rdata),
        .wmask      (align_wmask),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    // Upstream holds its fields only for the handshake cycle, so everything is latched here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dmem_req_q     <= 1'b0;
            memoryed_req_q <= 1'b0;
            pc_q           <= '0;
            inst_q         <= '0;
            opcode_q       <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            rd_wdata_q     <= '0;
            nocmt_q        <= 1'b0;
            skipcmt_q      <= 1'b0;
            addr_q         <= '0;
            store_data_q   <= '0;
            load_q         <= 1'b0;
            store_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mem_executed_req) begin
                        pc_q         <= i_mem_pc;
                        inst_q       <= i_mem_inst;
                        opcode_q     <= i_mem_inst_opcode;
                        rd_q         <= i_mem_rd;
                        rd_wen_q     <= i_mem_rd_wen;
                        rd_wdata_q   <= i_mem_rd_wdata;
                        nocmt_q      <= i_mem_nocmt;
                        skipcmt_q    <= i_mem_skipcmt;
                        addr_q       <= i_mem_op1 + i_mem_op2;
                        store_data_q <= i_mem_op3;
                        load_q       <= in_load;
                        store_q      <= in_store;
                        if (in_load || in_store) begin
                            state      <= MEM;
                            dmem_req_q <= 1'b1;
                        end else begin
                            state          <= DONE;
                            memoryed_req_q <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (i_mem_dmem_ack) begin
                        state          <= DONE;
                        dmem_req_q     <= 1'b0;
                        memoryed_req_q <= 1'b1;
                        if (load_q) begin
                            rd_wdata_q <= align_load;
                        end
                    end
                end
                DONE: begin
                    if (i_mem_memoryed_ack) begin
                        state          <= IDLE;
                        memoryed_req_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_STAGE_MMIO_SKIP_EN
    assign skip_eff = skipcmt_q | ((load_q | store_q) & (addr_q < 64'h0000_0000_8000_0000));
`else
    assign skip_eff = skipcmt_q;
`endif

    assign o_mem_executed_ack = (state == IDLE) & ~rst;

    assign o_mem_dmem_req   = dmem_req_q;
    assign o_mem_dmem_wen   = dmem_req_q & store_q;
    assign o_mem_dmem_addr  = dmem_req_q ? addr_q : '0;
    assign o_mem_dmem_wdata = (dmem_req_q & store_q) ? align_wdata : '0;
    assign o_mem_dmem_wmask = (dmem_req_q & store_q) ? align_wmask : 8'h00;

    // Results are visible only during the write-back handshake cycle.
    assign o_mem_memoryed_req = memoryed_req_q;
    assign wb_fire            = memoryed_req_q & i_mem_memoryed_ack;
    assign o_mem_pc           = wb_fire ? pc_q : '0;
    assign o_mem_inst         = wb_fire ? inst_q : '0;
    assign o_mem_rd           = wb_fire ? rd_q : '0;
    assign o_mem_rd_wen       = wb_fire & rd_wen_q & ~store_q;
    assign o_mem_rd_wdata     = wb_fire ? rd_wdata_q : '0;
    assign o_mem_nocmt        = wb_fire & nocmt_q;
    assign o_mem_skipcmt      = wb_fire & skip_eff;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset/stray-ack sequences,
// and randomized transactions checked against a byte-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MEM_STAGE_MMIO_SKIP_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_mem_executed_req;
    logic        o_mem_executed_ack;
    logic [4:0]  i_mem_inst_type;
    logic [7:0]  i_mem_inst_opcode;
    logic [63:0] i_mem_pc;
    logic [31:0] i_mem_inst;
    logic [63:0] i_mem_op1;
    logic [63:0] i_mem_op2;
    logic [63:0] i_mem_op3;
    logic [4:0]  i_mem_rd;
    logic        i_mem_rd_wen;
    logic [63:0] i_mem_rd_wdata;
    logic        i_mem_nocmt;
    logic        i_mem_skipcmt;
    logic        o_mem_dmem_req;
    logic        i_mem_dmem_ack;
    logic        o_mem_dmem_wen;
    logic [63:0] o_mem_dmem_addr;
    logic [63:0] o_mem_dmem_wdata;
    logic [7:0]  o_mem_dmem_wmask;
    logic [63:0] i_mem_dmem_rdata;
    logic        o_mem_memoryed_req;
    logic        i_mem_memoryed_ack;
    logic [63:0] o_mem_pc;
    logic [31:0] o_mem_inst;
    logic [4:0]  o_mem_rd;
    logic        o_mem_rd_wen;
    logic [63:0] o_mem_rd_wdata;
    logic        o_mem_nocmt;
    logic        o_mem_skipcmt;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic [7:0]  opc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] op3;
        logic [63:0] rdwd;
        logic [63:0] rdata;
        int          delay;
        logic [63:0] exp_addr;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
        logic        exp_rd_wen;
        logic [63:0] exp_rd_wdata;
        logic        exp_skip;
    } vec_t;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .i_mem_executed_req (i_mem_executed_req),
        .o_mem_executed_ack (o_mem_executed_ack),
        .i_mem_inst_type    (i_mem_inst_type),
        .i_mem_inst_opcode  (i_mem_inst_opcode),
        .i_mem_pc           (i_mem_pc),
        .i_mem_inst         (i_mem_inst),
        .i_mem_op1          (i_mem_op1),
        .i_mem_op2          (i_mem_op2),
        .i_mem_op3          (i_mem_op3),
        .i_mem_rd           (i_mem_rd),
        .i_mem_rd_wen       (i_mem_rd_wen),
        .i_mem_rd_wdata     (i_mem_rd_wdata),
        .i_mem_nocmt        (i_mem_nocmt),
        .i_mem_skipcmt      (i_mem_skipcmt),
        .o_mem_dmem_req     (o_mem_dmem_req),
        .i_mem_dmem_ack     (i_mem_dmem_ack),
        .o_mem_dmem_wen     (o_mem_dmem_wen),
        .o_mem_dmem_addr    (o_mem_dmem_addr),
        .o_mem_dmem_wdata   (o_mem_dmem_wdata),
        .o_mem_dmem_wmask   (o_mem_dmem_wmask),
        .i_mem_dmem_rdata   (i_mem_dmem_rdata),
        .o_mem_memoryed_req (o_mem_memoryed_req),
        .i_mem_memoryed_ack (i_mem_memoryed_ack),
        .o_mem_pc           (o_mem_pc),
        .o_mem_inst         (o_mem_inst),
        .o_mem_rd           (o_mem_rd),
        .o_mem_rd_wen       (o_mem_rd_wen),
        .o_mem_rd_wdata     (o_mem_rd_wdata),
        .o_mem_nocmt        (o_mem_nocmt),
        .o_mem_skipcmt      (o_mem_skipcmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Access size in bytes; zero means the opcode does not touch memory.
    function automatic int ref_bytes(input logic [7:0] opc);
        case (opc)
            INST_LB, INST_LBU, INST_SB: return 1;
            INST_LH, INST_LHU, INST_SH: return 2;
            INST_LW, INST_LWU, INST_SW: return 4;
            INST_LD, INST_SD:           return 8;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit ref_is_store(input logic [7:0] opc);
        return (opc == INST_SB) || (opc == INST_SH) || (opc == INST_SW) || (opc == INST_SD);
    endfunction

    function automatic bit ref_is_signed(input logic [7:0] opc);
        return (opc == INST_LB) || (opc == INST_LH) || (opc == INST_LW);
    endfunction

    // Byte-by-byte model: lanes beyond 7 are simply dropped.
    function automatic vec_t ref_model(input logic [7:0] opc, input logic [63:0] op1,
                                       input logic [63:0] op2, input logic [63:0] op3,
                                       input logic [63:0] rdwd, input logic [63:0] rdata,
                                       input int delay, input logic skip_in);
        vec_t        e;
        int          n;
        int          off;
        bit          st;
        logic [63:0] v;
        e.opc   = opc;   e.op1 = op1;   e.op2 = op2; e.op3 = op3;
        e.rdwd  = rdwd;  e.rdata = rdata; e.delay = delay;
        e.exp_addr  = op1 + op2;
        off         = int'(e.exp_addr[2:0]);
        n           = ref_bytes(opc);
        st          = ref_is_store(opc);
        e.exp_wmask = 8'h00;
        e.exp_wdata = op3 << (off * 8);
        v           = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) begin
                e.exp_wmask[off + i] = 1'b1;
                v[i*8 +: 8] = rdata[(off + i)*8 +: 8];
            end
        end
        if (ref_is_signed(opc) && v[n*8 - 1]) v = v | (~64'd0 << (n * 8));
        e.exp_rd_wen   = !st;
        e.exp_rd_wdata = (n != 0 && !st) ? v : rdwd;
        e.exp_skip     = skip_in | (MMIO_EN && n != 0 && e.exp_addr < 64'h8000_0000);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic scrambleInputs();
        i_mem_inst_type   = 5'($urandom);
        i_mem_inst_opcode = 8'($urandom);
        i_mem_pc          = {$urandom, $urandom};
        i_mem_inst        = $urandom;
        i_mem_op1         = {$urandom, $urandom};
        i_mem_op2         = {$urandom, $urandom};
        i_mem_op3         = {$urandom, $urandom};
        i_mem_rd          = 5'($urandom);
        i_mem_rd_wen      = 1'($urandom);
        i_mem_rd_wdata    = {$urandom, $urandom};
        i_mem_nocmt       = 1'($urandom);
        i_mem_skipcmt     = 1'($urandom);
    endtask

    // Runs one full transaction starting and ending at a negative clock edge.
    task automatic applyStimulus(input vec_t v, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic [4:0] rd, input logic nocmt, input logic skip_in,
                                 input int wb_delay);
        bit is_mem;
        bit st;
        is_mem = ref_bytes(v.opc) != 0;
        st     = ref_is_store(v.opc);
        i_mem_inst_type    = 5'($urandom);
        i_mem_inst_opcode  = v.opc;
        i_mem_pc           = pc;
        i_mem_inst         = inst;
        i_mem_op1          = v.op1;
        i_mem_op2          = v.op2;
        i_mem_op3          = v.op3;
        i_mem_rd           = rd;
        i_mem_rd_wen       = 1'b1;
        i_mem_rd_wdata     = v.rdwd;
        i_mem_nocmt        = nocmt;
        i_mem_skipcmt      = skip_in;
        i_mem_executed_req = 1'b1;
        #1;
        checkOutput("executed_ack_idle", o_mem_executed_ack, 1);
        @(posedge clk);
        #1;
        i_mem_executed_req = 1'b0;
        scrambleInputs();
        @(negedge clk);
        if (is_mem) begin
            checkOutput("dmem_req_first", o_mem_dmem_req, 1);
            checkOutput("dmem_addr", o_mem_dmem_addr, v.exp_addr);
            checkOutput("dmem_wen", o_mem_dmem_wen, st);
            if (st) begin
                checkOutput("dmem_wmask", o_mem_dmem_wmask, v.exp_wmask);
                checkOutput("dmem_wdata", o_mem_dmem_wdata, v.exp_wdata);
            end
            checkOutput("mem_flags", {o_mem_executed_ack, o_mem_memoryed_req}, 2'b00);
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk);
                checkOutput("dmem_hold_flags", {o_mem_dmem_req, o_mem_executed_ack, o_mem_memoryed_req}, 3'b100);
                checkOutput("dmem_hold_addr", o_mem_dmem_addr, v.exp_addr);
            end
            i_mem_dmem_ack   = 1'b1;
            i_mem_dmem_rdata = v.rdata;
            @(posedge clk);
            #1;
            i_mem_dmem_ack   = 1'b0;
            i_mem_dmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("dmem_req_dropped", o_mem_dmem_req, 0);
        end else begin
            checkOutput("nonmem_dmem_req", o_mem_dmem_req, 0);
        end
        checkOutput("memoryed_req_rise", o_mem_memoryed_req, 1);
        checkOutput("rd_wdata_gated", o_mem_rd_wdata, 0);
        for (int i = 0; i < wb_delay; i++) begin
            @(negedge clk);
            checkOutput("memoryed_req_hold", {o_mem_memoryed_req, o_mem_executed_ack}, 2'b10);
        end
        i_mem_memoryed_ack = 1'b1;
        #1;
        checkOutput("wb_pc", o_mem_pc, pc);
        checkOutput("wb_inst", o_mem_inst, inst);
        checkOutput("wb_rd", o_mem_rd, rd);
        checkOutput("wb_rd_wen", o_mem_rd_wen, v.exp_rd_wen);
        checkOutput("wb_rd_wdata", o_mem_rd_wdata, v.exp_rd_wdata);
        checkOutput("wb_nocmt", o_mem_nocmt, nocmt);
        checkOutput("wb_skipcmt", o_mem_skipcmt, v.exp_skip);
        @(posedge clk);
        #1;
        i_mem_memoryed_ack = 1'b0;
        @(negedge clk);
        checkOutput("post_wb_flags", {o_mem_memoryed_req, o_mem_executed_ack}, 2'b01);
    endtask

    logic [7:0] opc_list [13] = '{INST_ADD, INST_SUB, INST_LB, INST_LH, INST_LW, INST_LD,
                                  INST_LBU, INST_LHU, INST_LWU, INST_SB, INST_SH, INST_SW, INST_SD};

    initial begin
        vec_t tbl [12];
        vec_t v;

        tbl[0]  = '{INST_ADD, 64'd5, 64'd7, 64'd0, 64'h1234, 64'd0, 0,
                    64'd12, 8'h00, 64'd0, 1'b1, 64'h1234, 1'b0};
        tbl[1]  = '{INST_LB, 64'h8000_0000, 64'd3, 64'd0, 64'hAAAA, 64'h0000_0000_8000_0000, 1,
                    64'h8000_0003, 8'h00, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        tbl[2]  = '{INST_LBU, 64'h8000_0000, 64'd3, 64'd0, 64'hAAAA, 64'h0000_0000_8000_0000, 0,
                    64'h8000_0003, 8'h00, 64'd0, 1'b1, 64'h80, 1'b0};
        tbl[3]  = '{INST_SH, 64'h8000_0000, 64'd6, 64'hABCD, 64'h5555, 64'd0, 0,
                    64'h8000_0006, 8'hC0, 64'hABCD_0000_0000_0000, 1'b0, 64'h5555, 1'b0};
        tbl[4]  = '{INST_LD, 64'h8000_1000, 64'd8, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 5,
                    64'h8000_1008, 8'h00, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
        tbl[5]  = '{INST_SW, 64'h0200_4000, 64'd0, 64'hDEAD_BEEF, 64'd0, 64'd0, 2,
                    64'h0200_4000, 8'h0F, 64'hDEAD_BEEF, 1'b0, 64'd0, MMIO_EN};
        tbl[6]  = '{INST_SW, 64'h8000_0000, 64'd7, 64'h1122_3344, 64'd0, 64'd0, 0,
                    64'h8000_0007, 8'h80, 64'h4400_0000_0000_0000, 1'b0, 64'd0, 1'b0};
        tbl[7]  = '{INST_LH, 64'h8000_0000, 64'd7, 64'd0, 64'd0, 64'h9000_0000_0000_0000, 0,
                    64'h8000_0007, 8'h00, 64'd0, 1'b1, 64'h90, 1'b0};
        tbl[8]  = '{INST_LW, 64'h8000_0000, 64'd4, 64'd0, 64'd0, 64'h8765_4321_0000_0000, 1,
                    64'h8000_0004, 8'h00, 64'd0, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0};
        tbl[9]  = '{INST_LWU, 64'h8000_0000, 64'd4, 64'd0, 64'd0, 64'h8765_4321_0000_0000, 0,
                    64'h8000_0004, 8'h00, 64'd0, 1'b1, 64'h8765_4321, 1'b0};
        tbl[10] = '{INST_SD, 64'h8000_0010, 64'd0, 64'hCAFE_F00D_1234_5678, 64'd0, 64'd0, 0,
                    64'h8000_0010, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0, 64'd0, 1'b0};
        tbl[11] = '{INST_LB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, 64'h7F00, 0,
                    64'd1, 8'h00, 64'd0, 1'b1, 64'h7F, MMIO_EN};

        rst                = 1'b1;
        i_mem_executed_req = 1'b0;
        i_mem_dmem_ack     = 1'b0;
        i_mem_dmem_rdata   = 64'd0;
        i_mem_memoryed_ack = 1'b0;
        scrambleInputs();

        repeat (2) @(negedge clk);
        checkOutput("reset_executed_ack", o_mem_executed_ack, 0);
        checkOutput("reset_reqs", {o_mem_dmem_req, o_mem_memoryed_req, o_mem_dmem_wen}, 3'b000);
        checkOutput("reset_dmem_addr", o_mem_dmem_addr, 0);
        checkOutput("reset_dmem_wdata", {o_mem_dmem_wdata[55:0], o_mem_dmem_wmask}, 0);
        checkOutput("reset_result", o_mem_rd_wdata | o_mem_pc, 0);
        checkOutput("reset_result_flags", {o_mem_rd_wen, o_mem_nocmt, o_mem_skipcmt, o_mem_rd}, 0);
        rst = 1'b0;
        #1;
        checkOutput("executed_ack_after_reset", o_mem_executed_ack, 1);

        // Stray acks while idle must not start anything.
        i_mem_dmem_ack     = 1'b1;
        i_mem_memoryed_ack = 1'b1;
        @(posedge clk);
        #1;
        i_mem_dmem_ack     = 1'b0;
        i_mem_memoryed_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray_ack_idle", {o_mem_dmem_req, o_mem_memoryed_req, o_mem_executed_ack}, 3'b001);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], 64'h1000 + 64'(i * 4), 32'h0013_0000 + 32'(i), 5'(i + 1),
                          1'(i % 2), 1'b0, i % 3);
        end

        // Reset during an outstanding load abandons it.
        i_mem_inst_opcode  = INST_LD;
        i_mem_op1          = 64'h8000_2000;
        i_mem_op2          = 64'd0;
        i_mem_executed_req = 1'b1;
        @(posedge clk);
        #1;
        i_mem_executed_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_dmem_req", o_mem_dmem_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_flags", {o_mem_dmem_req, o_mem_executed_ack, o_mem_memoryed_req}, 3'b010);
        i_mem_dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        i_mem_dmem_ack = 1'b0;
        checkOutput("rst_mem_no_result", {o_mem_dmem_req, o_mem_memoryed_req}, 2'b00);

        for (int i = 0; i < 60; i++) begin
            logic [7:0]  opc;
            logic [63:0] op1;
            logic [63:0] op2;
            logic        skip_in;
            opc     = opc_list[$urandom_range(0, 12)];
            op1     = ($urandom_range(0, 1) == 1) ? {32'd0, $urandom} : {$urandom, $urandom};
            op2     = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 64));
            skip_in = ($urandom_range(0, 4) == 0);
            v = ref_model(opc, op1, op2, {$urandom, $urandom}, {$urandom, $urandom},
                          {$urandom, $urandom}, $urandom_range(0, 3), skip_in);
            applyStimulus(v, {$urandom, $urandom}, $urandom, 5'($urandom), 1'($urandom),
                          skip_in, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
